serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-002 SHALL have parameter DIGIT, default 2, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-low reset; 0 sampled at a clock edge resets the block.
REQ-006 io_in_valid  input  1  operands are offered.
REQ-007 io_in_ready  output  1  block accepts operands.
REQ-008 io_a  input  WIDTH  operand A.
REQ-009 io_b  input  WIDTH  operand B.
REQ-010 io_cin  input  1  carry-in, or borrow-in when subtracting.
REQ-011 io_sub  input  1  1 = subtract, 0 = add; sampled with operands.
REQ-012 io_out_valid  output  1  result is available.
REQ-013 io_out_ready  input  1  consumer takes the result.
REQ-014 io_sum  output  WIDTH  result.
REQ-015 io_cout  output  1  final carry-out; raw carry, so for subtract 1 = no borrow.
REQ-016 io_busy  output  1  high in BUSY state.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE; BEATS = WIDTH/DIGIT.
REQ-018 IDLE: io_in_ready=1. On io_in_valid&&io_in_ready, latch io_a, io_b XOR {WIDTH{io_sub}}, carry = io_cin XOR io_sub, and the beat counter = 0; go to BUSY.
REQ-019 BUSY: each cycle, add the DIGIT LSBs of both shift registers plus carry; shift the DIGIT-bit sum into the result MSBs; update carry; increment the counter.
REQ-020 After beat BEATS-1 SHALL go to DONE, so io_out_valid rises exactly BEATS cycles after the accepting edge.
REQ-021 DONE: io_out_valid=1, with io_sum and io_cout stable; on io_out_ready go to IDLE at that edge.
REQ-022 io_in_ready SHALL be 0 in BUSY and DONE; io_in_valid there is ignored, and there is no overlap of operations.
REQ-023 io_out_ready SHALL be ignored outside DONE.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH: add gives a+b+cin; subtract gives a-b-cin.
REQ-025 When DIGIT==WIDTH, BEATS=1 and the result is valid one cycle after accept.
REQ-026 io_sum and io_cout SHALL hold their last result outside DONE until the next DONE.

Reset
REQ-027 reset=0 at an edge SHALL force IDLE from any state, including mid-BUSY; any in-flight operation is discarded.
REQ-028 Reset values: io_in_ready=1, io_out_valid=0, io_busy=0, io_sum=0, io_cout=0, counter=0, carry=0.
REQ-029 The first accept after release SHALL be possible on the first edge with reset=1.

Configuration
REQ-030 Macro SERIAL_ADDER_OVF_EN defined: SHALL add output io_ovf (1 bit), the signed two's-complement overflow of the completed operation.
REQ-031 io_ovf SHALL be carry into the MSB XOR carry out of the MSB, registered with io_sum, valid in DONE, and reset to 0.
REQ-032 Macro undefined: io_ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8, DIGIT=2)
REQ-033 Add: a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0; io_out_valid exactly 4 cycles after the accept edge; io_busy high 4 cycles.
REQ-034 Wrap: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1.
REQ-035 Subtract: a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout=0, ovf=0; a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-036 Overflow (macro on): add 0x7F+0x01 -> sum=0x80, ovf=1; sub 0x80-0x01 -> sum=0x7F, ovf=1.
REQ-037 Backpressure: io_out_ready=0 for 10 cycles in DONE while io_in_valid=1 with new operands -> io_out_valid stays 1, sum unchanged, io_in_ready=0, and no new accept until one cycle after io_out_ready=1.
REQ-038 Mid-op reset: reset=0 for one edge during beat 2 -> next cycle IDLE, io_out_valid=0, io_in_ready=1, sum=0; the next operation computes correctly.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits are processed per cycle over WIDTH/DIGIT beats.
// Defining SERIAL_ADDER_OVF_EN adds io_ovf, the signed overflow of the completed operation.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    input  logic             io_cin,
    input  logic             io_sub,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_sum,
    output logic             io_cout,
    output logic             io_busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             io_ovf
`endif
);
    localparam int BEATS = WIDTH / DIGIT;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIGIT:0]   beatSum;
    logic             accept;
    logic             lastBeat;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign accept   = (state_q == IDLE) && io_in_valid;
    assign lastBeat = (state_q == BUSY) && (cnt_q == LAST_BEAT);
    assign beatSum  = {1'b0, aShift_q[DIGIT-1:0]} + {1'b0, bShift_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (io_in_valid)  state_d = BUSY;
            BUSY:    if (lastBeat)     state_d = DONE;
            DONE:    if (io_out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io_in_ready  = (state_q == IDLE);
        io_busy      = (state_q == BUSY);
        io_out_valid = (state_q == DONE);
    end

    // Subtraction is a + ~b + ~borrow, so b and the carry are inverted once at accept.
    always_comb begin
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            aShift_d = io_a;
            bShift_d = io_b ^ {WIDTH{io_sub}};
            carry_d  = io_cin ^ io_sub;
            cnt_d    = '0;
        end else if (state_q == BUSY) begin
            aShift_d = aShift_q >> DIGIT;
            bShift_d = bShift_q >> DIGIT;
            acc_d    = acc_q >> DIGIT;
            acc_d[WIDTH-1 -: DIGIT] = beatSum[DIGIT-1:0];
            carry_d  = beatSum[DIGIT];
            cnt_d    = cnt_q + CNT_W'(1);
            // The visible result only changes when the final beat lands.
            if (lastBeat) begin
                sum_d  = acc_d;
                cout_d = beatSum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                ovf_d  = aShift_q[DIGIT-1] ^ bShift_q[DIGIT-1]
                       ^ beatSum[DIGIT-1] ^ beatSum[DIGIT];
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            aShift_q <= '0;
            bShift_q <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign io_sum  = sum_q;
    assign io_cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign io_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver queues reference results at accept,
// and a negedge monitor compares every DONE cycle and checks hold/reset behaviour.
`timescale 1ns/1ps
module tb_serial_adder;
    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int BEATS = WIDTH / DIGIT;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acceptCycle;
    } expT;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             ioInValid = 1'b0;
    logic             ioOutReady = 1'b0;
    logic             ioCin = 1'b0;
    logic             ioSub = 1'b0;
    logic [WIDTH-1:0] ioA = '0;
    logic [WIDTH-1:0] ioB = '0;
    logic             ioInReady;
    logic             ioOutValid;
    logic             ioCout;
    logic             ioBusy;
    logic [WIDTH-1:0] ioSum;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ioOvf;
`endif

    int  checks = 0;
    int  errors = 0;
    int  cycle = 0;
    bit  randReady = 1'b0;
    expT expQ[$];

    serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (ioInValid),
        .io_in_ready  (ioInReady),
        .io_a         (ioA),
        .io_b         (ioB),
        .io_cin       (ioCin),
        .io_sub       (ioSub),
        .io_out_valid (ioOutValid),
        .io_out_ready (ioOutReady),
        .io_sum       (ioSum),
        .io_cout      (ioCout),
        .io_busy      (ioBusy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .io_ovf       (ioOvf)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    always @(posedge clock) begin
        if (randReady) begin
            #1 ioOutReady = 1'($urandom_range(0, 1));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values, signed range for overflow.
    function automatic expT refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic cin, input logic sub);
        expT e;
        int  ua = int'(a);
        int  ub = int'(b);
        int  ci = int'(cin);
        int  sa = int'($signed(a));
        int  sb = int'($signed(b));
        int  r;
        int  sr;
        if (!sub) begin
            r      = ua + ub + ci;
            sr     = sa + sb + ci;
            e.cout = (r >= (1 << WIDTH));
        end else begin
            r      = ua - ub - ci;
            sr     = sa - sb - ci;
            e.cout = (ua >= ub + ci);
        end
        e.sum         = r[WIDTH-1:0];
        e.ovf         = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
        e.acceptCycle = 0;
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
        int  waited = 0;
        expT e;
        ioA = a;
        ioB = b;
        ioCin = cin;
        ioSub = sub;
        ioInValid = 1'b1;
        @(negedge clock);
        while (!ioInReady && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (!ioInReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: in_ready still 0 after %0d cycles, expected 1", waited);
        end else begin
            e = refModel(a, b, cin, sub);
            e.acceptCycle = cycle + 1;
            expQ.push_back(e);
        end
        step();
        ioInValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || ioOutValid) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain timeout: %0d results pending, expected 0", expQ.size());
        end
    endtask

    logic [WIDTH-1:0] lastSum = '0;
    logic             lastCout = 1'b0;
    logic             lastOvf = 1'b0;
    bit               armed = 1'b0;
    bit               resetFollow = 1'b0;
    bit               prevValid = 1'b0;
    int               busyCnt = 0;

    // Monitor: checks happen first on current outputs, then a low reset flushes the scoreboard.
    always @(negedge clock) begin
        if (armed) begin
            if (resetFollow) begin
                checkOutput("reset in_ready", ioInReady, 1);
                checkOutput("reset out_valid", ioOutValid, 0);
                checkOutput("reset busy", ioBusy, 0);
                checkOutput("reset sum", ioSum, 0);
                checkOutput("reset cout", ioCout, 0);
                resetFollow = 1'b0;
            end
            if (ioBusy) begin
                busyCnt++;
                checkOutput("busy in_ready", ioInReady, 0);
            end
            if (ioOutValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected result: sum 0x%0h with no operation pending", ioSum);
                end else begin
                    if (!prevValid) begin
                        checkOutput("latency", cycle - expQ[0].acceptCycle, BEATS);
                        checkOutput("busy cycles", busyCnt, BEATS);
                        busyCnt = 0;
                    end
                    checkOutput("sum", ioSum, expQ[0].sum);
                    checkOutput("cout", ioCout, expQ[0].cout);
`ifdef SERIAL_ADDER_OVF_EN
                    checkOutput("ovf", ioOvf, expQ[0].ovf);
`endif
                    checkOutput("done in_ready", ioInReady, 0);
                    lastSum  = expQ[0].sum;
                    lastCout = expQ[0].cout;
                    lastOvf  = expQ[0].ovf;
                    if (ioOutReady) void'(expQ.pop_front());
                end
            end else begin
                checkOutput("hold sum", ioSum, lastSum);
                checkOutput("hold cout", ioCout, lastCout);
`ifdef SERIAL_ADDER_OVF_EN
                checkOutput("hold ovf", ioOvf, lastOvf);
`endif
            end
            prevValid = ioOutValid;
        end
        if (!reset) begin
            expQ.delete();
            lastSum     = '0;
            lastCout    = 1'b0;
            lastOvf     = 1'b0;
            armed       = 1'b1;
            resetFollow = 1'b1;
            prevValid   = 1'b0;
            busyCnt     = 0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] edgeVals [4];
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        edgeVals = '{8'h00, 8'h7F, 8'h80, 8'hFF};

        ioOutReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        // First accept lands on the first edge with reset high.
        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
        waitDrain();
        applyStimulus(8'h05, 8'h07, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(8'h07, 8'h05, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1);
        waitDrain();

        // Backpressure: result held for 10 DONE cycles while new operands wait.
        ioOutReady = 1'b0;
        applyStimulus(8'h12, 8'h34, 1'b1, 1'b0);
        fork
            applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b1);
            begin
                int n = 0;
                @(negedge clock);
                while (!ioOutValid && n < 20) begin
                    @(negedge clock);
                    n++;
                end
                if (!ioOutValid) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL done timeout: out_valid 0, expected 1");
                end
                repeat (10) @(posedge clock);
                #1;
                ioOutReady = 1'b1;
            end
        join
        waitDrain();

        // Reset sampled at the edge that would perform beat 2.
        applyStimulus(8'h33, 8'h44, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        applyStimulus(8'h9C, 8'h27, 1'b1, 1'b1);
        waitDrain();

        randReady = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : WIDTH'($urandom);
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        randReady = 1'b0;
        step();
        ioOutReady = 1'b1;
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
